dma_mm2s_engine: RTL and testbench



---
 rtl/dma_pkg.sv | 20 ++
 rtl/dma_burst_calc.sv | 28 ++
 rtl/dma_mm2s_engine.sv | 244 ++++++++++++++++++++++++
 tb/tb_dma_mm2s_engine.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared constants and types for the MM2S DMA engine:
// completion codes, AXI burst encoding and FSM states.
package dma_pkg;

  localparam logic [3:0] DMA_OK       = 4'd0;
  localparam logic [3:0] DMA_ERR_LEN  = 4'd1;
  localparam logic [3:0] DMA_ERR_SLV  = 4'd2;
  localparam logic [3:0] DMA_ERR_DEC  = 4'd3;
  localparam logic [3:0] DMA_ERR_LAST = 4'd4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AR,
    ST_DATA,
    ST_STATUS
  } dma_mm2s_state_e;

endpackage

// File: rtl/dma_burst_calc.sv
// Beats for the next AR burst: min(remaining, MAX_BURST, beats to 4 KB edge).
// Ports: rem (beats left), addr_lo (addr[11:0]) -> beats (1..256).
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int REM_WIDTH = 32,
  parameter int BYTES     = 4,
  parameter int MAX_BURST = 16
) (
  input  logic [REM_WIDTH-1:0] rem,
  input  logic [11:0]          addr_lo,
  output logic [8:0]           beats
);

  localparam int SZ = $clog2(BYTES);

  logic [12:0] room;
  logic [12:0] lim;

  always_comb begin
    room = (13'd4096 - {1'b0, addr_lo}) >> SZ;
    lim  = 13'(MAX_BURST);
    if (room < lim) lim = room;
    if (rem < REM_WIDTH'(lim)) beats = 9'(rem);
    else                       beats = 9'(lim);
  end

endmodule

// File: rtl/dma_mm2s_engine.sv
// MM2S executor: descriptor in, AXI4 INCR reads out, AXIS stream + status.
// Ports: desc_* handshake, status_*, m_axi_ar*/r*, m_axis_*;
// DMA_MM2S_STATS_EN adds stat_desc_count / stat_beat_count.
module dma_mm2s_engine
  import dma_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_LEN_WIDTH   = 32,
  parameter int AXIS_USER_WIDTH = 65,
  parameter int MAX_BURST       = 16,
  localparam int BYTES      = AXI_DATA_WIDTH / 8,
  localparam int DESC_WIDTH = AXI_ADDR_WIDTH + AXI_LEN_WIDTH
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [DESC_WIDTH-1:0]      desc_data,
  input  logic [AXIS_USER_WIDTH-1:0] desc_user,
  input  logic                       desc_valid,
  output logic                       desc_ready,
  output logic [3:0]                 status_error,
  output logic                       status_valid,
  output logic [AXI_ADDR_WIDTH-1:0]  m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]  m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready,
  output logic [AXI_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [BYTES-1:0]           m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic [AXIS_USER_WIDTH-1:0] m_axis_tuser,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready
`ifdef DMA_MM2S_STATS_EN
  ,
  output logic [31:0]                stat_desc_count,
  output logic [31:0]                stat_beat_count
`endif
);

  localparam int AW = AXI_ADDR_WIDTH;
  localparam int LW = AXI_LEN_WIDTH;
  localparam int SZ = $clog2(BYTES);

  dma_mm2s_state_e state_q, state_d;

  logic [AW-1:0]              addr_q, addr_d;
  logic [LW-1:0]              rem_q, rem_d;
  logic [AXIS_USER_WIDTH-1:0] user_q, user_d;
  logic [3:0]                 err_q, err_d;
  logic [8:0]                 burst_q, burst_d;
  logic [8:0]                 cnt_q, cnt_d;
  logic                       arvalid_q, arvalid_d;
  logic [AW-1:0]              araddr_q, araddr_d;
  logic [7:0]                 arlen_q, arlen_d;

  logic [LW-1:0] desc_len;
  logic [AW-1:0] desc_addr;
  logic          desc_bad;
  logic          in_data;
  logic          r_hs;
  logic          ar_hs;
  logic          burst_end;
  logic          ar_load;
  logic [8:0]    nxt_beats;

  assign desc_len  = desc_data[DESC_WIDTH-1:AW];
  assign desc_addr = desc_data[AW-1:0];
  assign desc_bad  = (desc_len == '0)
                   || ((desc_len & LW'(BYTES-1)) != '0)
                   || ((desc_addr & AW'(BYTES-1)) != '0);

  assign in_data   = (state_q == ST_DATA);
  assign r_hs      = in_data && m_axi_rvalid && m_axis_tready;
  assign ar_hs     = (state_q == ST_AR) && arvalid_q && m_axi_arready;
  assign burst_end = ((cnt_q + 9'd1) == burst_q);

  // Sized from the values the next burst will start from.
  dma_burst_calc #(
    .REM_WIDTH (LW),
    .BYTES     (BYTES),
    .MAX_BURST (MAX_BURST)
  ) u_calc (
    .rem     (rem_d),
    .addr_lo (addr_d[11:0]),
    .beats   (nxt_beats)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (desc_valid) state_d = desc_bad ? ST_STATUS : ST_AR;
      end
      ST_AR: begin
        if (ar_hs) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (r_hs && burst_end)
          state_d = (rem_q != LW'(1)) ? ST_AR : ST_STATUS;
      end
      ST_STATUS: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    rem_d   = rem_q;
    user_d  = user_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    ar_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (desc_valid) begin
          addr_d  = desc_addr;
          user_d  = desc_user;
          err_d   = desc_bad ? DMA_ERR_LEN : DMA_OK;
          rem_d   = desc_bad ? '0 : (desc_len >> SZ);
          cnt_d   = '0;
          ar_load = !desc_bad;
        end
      end
      ST_AR: cnt_d = '0;
      ST_DATA: begin
        if (r_hs) begin
          rem_d = rem_q - LW'(1);
          cnt_d = cnt_q + 9'd1;
          // First cause wins; the beat counter, not rlast, ends a burst.
          if (err_q == DMA_OK) begin
            if (m_axi_rresp == 2'b10)
              err_d = DMA_ERR_SLV;
            else if (m_axi_rresp == 2'b11)
              err_d = DMA_ERR_DEC;
            else if (m_axi_rlast != burst_end)
              err_d = DMA_ERR_LAST;
          end
          if (burst_end) begin
            addr_d  = addr_q + (AW'(burst_q) << SZ);
            cnt_d   = '0;
            ar_load = (rem_q != LW'(1));
          end
        end
      end
      default: ;
    endcase
  end

  // AR fields are captured once per burst so they stay put until arready.
  always_comb begin
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    burst_d   = burst_q;
    if (ar_hs) arvalid_d = 1'b0;
    if (ar_load) begin
      arvalid_d = 1'b1;
      araddr_d  = addr_d;
      arlen_d   = 8'(nxt_beats - 9'd1);
      burst_d   = nxt_beats;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q    <= '0;
      rem_q     <= '0;
      user_q    <= '0;
      err_q     <= DMA_OK;
      cnt_q     <= '0;
      burst_q   <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
    end else begin
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      user_q    <= user_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      burst_q   <= burst_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
    end
  end

  always_comb begin
    desc_ready    = (state_q == ST_IDLE);
    status_valid  = (state_q == ST_STATUS);
    status_error  = status_valid ? err_q : 4'd0;
    m_axi_araddr  = araddr_q;
    m_axi_arlen   = arlen_q;
    m_axi_arvalid = arvalid_q;
    m_axi_arsize  = arvalid_q ? 3'(SZ) : 3'd0;
    m_axi_arburst = arvalid_q ? AXI_BURST_INCR : 2'b00;
    m_axi_rready  = in_data && m_axis_tready;
    m_axis_tvalid = in_data && m_axi_rvalid;
    m_axis_tdata  = in_data ? m_axi_rdata : '0;
    m_axis_tkeep  = in_data ? '1 : '0;
    m_axis_tlast  = in_data && (rem_q == LW'(1));
    m_axis_tuser  = user_q;
  end

`ifdef DMA_MM2S_STATS_EN
  logic [31:0] desc_cnt_q, desc_cnt_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    desc_cnt_d = desc_cnt_q;
    beat_cnt_d = beat_cnt_q;
    if (status_valid && (err_q == DMA_OK))
      desc_cnt_d = desc_cnt_q + 32'd1;
    if (r_hs)
      beat_cnt_d = beat_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      desc_cnt_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      desc_cnt_q <= desc_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign stat_desc_count = desc_cnt_q;
  assign stat_beat_count = beat_cnt_q;
`endif

endmodule

// File: tb/tb_dma_mm2s_engine.sv
// Directed bench for dma_mm2s_engine: AXI read slave model,
// AXIS monitor and per-descriptor completion checks.
module tb_dma_mm2s_engine;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [63:0]  desc_data;
  logic [64:0]  desc_user;
  logic         desc_valid;
  logic         desc_ready;
  logic [3:0]   status_error;
  logic         status_valid;
  logic [31:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic [1:0]   m_axi_arburst;
  logic         m_axi_arvalid;
  logic         m_axi_arready;
  logic [31:0]  m_axi_rdata;
  logic [1:0]   m_axi_rresp;
  logic         m_axi_rlast;
  logic         m_axi_rvalid;
  logic         m_axi_rready;
  logic [31:0]  m_axis_tdata;
  logic [3:0]   m_axis_tkeep;
  logic         m_axis_tlast;
  logic [64:0]  m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
`ifdef DMA_MM2S_STATS_EN
  logic [31:0]  stat_desc_count;
  logic [31:0]  stat_beat_count;
`endif

  always #5 clk = ~clk;

  dma_mm2s_engine #(
    .AXI_ADDR_WIDTH  (32),
    .AXI_DATA_WIDTH  (32),
    .AXI_LEN_WIDTH   (32),
    .AXIS_USER_WIDTH (65),
    .MAX_BURST       (16)
  ) dut (
`ifdef DMA_MM2S_STATS_EN
    .stat_desc_count (stat_desc_count),
    .stat_beat_count (stat_beat_count),
`endif
    .clk           (clk),
    .rstn          (rstn),
    .desc_data     (desc_data),
    .desc_user     (desc_user),
    .desc_valid    (desc_valid),
    .desc_ready    (desc_ready),
    .status_error  (status_error),
    .status_valid  (status_valid),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [79:0] obs,
                     input logic [79:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [7:0]  l;
  } burst_t;

  int          ar_cnt = 0;
  int          beats_seen = 0;
  int          tlast_cnt = 0;
  int          st_cnt = 0;
  logic [3:0]  st_err = '0;
  logic [31:0] ar_a [8];
  logic [7:0]  ar_l [8];
  logic [31:0] exp_addr = '0;
  int          exp_total = 0;
  logic [64:0] exp_user = '0;
  int          err_beat = -1;
  logic        drop_rlast = 1'b0;
  logic        tgl = 1'b0;
  int          ar_delay = 0;

  // AXI read slave (rdata = byte address of the beat) plus AXIS monitor.
  initial begin : slave
    logic        ar_hs, r_hs, prev_arv, prev_hs;
    logic [31:0] prev_a, hs_a;
    logic [7:0]  prev_l, hs_l;
    int          r_bi, ar_wait;
    burst_t      q [$];
    prev_arv = 0; prev_hs = 0; prev_a = 0; prev_l = 0;
    hs_a = 0; hs_l = 0; r_bi = 0; ar_wait = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0;
    m_axi_rresp = 0; m_axi_rlast = 0; m_axis_tready = 1;
    forever begin
      @(negedge clk);
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      if (rstn) begin
        if (m_axi_arvalid && prev_arv && !prev_hs) begin
          chk("ar_addr_stable", m_axi_araddr, prev_a);
          chk("ar_len_stable", m_axi_arlen, prev_l);
        end
        if (ar_hs) begin
          if (ar_cnt < 8) begin
            ar_a[ar_cnt] = m_axi_araddr;
            ar_l[ar_cnt] = m_axi_arlen;
          end
          ar_cnt++;
          hs_a = m_axi_araddr;
          hs_l = m_axi_arlen;
          chk("arsize", m_axi_arsize, 3'd2);
          chk("arburst", m_axi_arburst, 2'b01);
        end
        if (m_axi_rvalid)
          chk("rready_tracks_tready", m_axi_rready, m_axis_tready);
        if (m_axis_tvalid && m_axis_tready) begin
          chk("tdata", m_axis_tdata, exp_addr);
          chk("tlast", m_axis_tlast, 1'(beats_seen == exp_total - 1));
          chk("tuser", m_axis_tuser, exp_user);
          chk("tkeep", m_axis_tkeep, 4'hF);
          if (m_axis_tlast) tlast_cnt++;
          exp_addr = exp_addr + 32'd4;
          beats_seen++;
        end
        if (status_valid) begin
          st_cnt++;
          st_err = status_error;
        end
      end
      prev_arv = m_axi_arvalid && rstn;
      prev_hs  = ar_hs;
      prev_a   = m_axi_araddr;
      prev_l   = m_axi_arlen;
      @(posedge clk);
      #1;
      if (!rstn) begin
        q.delete();
        r_bi = 0; ar_wait = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0;
        m_axi_rresp = 0; m_axi_rlast = 0; m_axis_tready = 1;
        prev_arv = 0;
      end else begin
        if (ar_hs) q.push_back('{a: hs_a, l: hs_l});
        if (r_hs && q.size() > 0) begin
          r_bi++;
          if (r_bi > int'(q[0].l)) begin
            void'(q.pop_front());
            r_bi = 0;
          end
        end
        if (m_axi_arvalid) begin
          m_axi_arready = (ar_wait >= ar_delay);
          ar_wait++;
        end else begin
          m_axi_arready = 0;
          ar_wait = 0;
        end
        if (q.size() > 0) begin
          m_axi_rvalid = 1;
          m_axi_rdata  = q[0].a + 32'(4 * r_bi);
          m_axi_rlast  = (r_bi == int'(q[0].l)) && !drop_rlast;
          m_axi_rresp  = (beats_seen == err_beat) ? 2'b10 : 2'b00;
        end else begin
          m_axi_rvalid = 0;
          m_axi_rdata  = 0;
          m_axi_rlast  = 0;
          m_axi_rresp  = 0;
        end
        m_axis_tready = tgl ? ~m_axis_tready : 1'b1;
      end
    end
  end

  task automatic send_desc(input logic [31:0] a, input logic [31:0] l,
                           input logic [64:0] u, input int errb,
                           input logic drop);
    int cyc;
    logic acc;
    @(posedge clk);
    #1;
    ar_cnt = 0; beats_seen = 0; tlast_cnt = 0; st_cnt = 0;
    exp_addr = a; exp_total = int'(l / 4); exp_user = u;
    err_beat = errb; drop_rlast = drop;
    desc_data = {l, a};
    desc_user = u;
    desc_valid = 1;
    acc = 0;
    cyc = 0;
    while (!acc && cyc < 50) begin
      @(negedge clk);
      if (desc_ready) acc = 1;
      cyc++;
      @(posedge clk);
      #1;
    end
    desc_valid = 0;
    if (!acc) chk("desc_accept_timeout", 0, 1);
  endtask

  task automatic run_desc(input string nm, input logic [31:0] a,
                          input logic [31:0] l, input logic [64:0] u,
                          input int errb, input logic drop,
                          input logic [3:0] exp_err, input int exp_beats,
                          input int exp_ars);
    int cyc;
    send_desc(a, l, u, errb, drop);
    cyc = 0;
    while (st_cnt == 0 && cyc < 3000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (st_cnt == 0) chk({nm, "_status_timeout"}, 0, 1);
    if (exp_err == 4'd1) chk({nm, "_status_latency"}, cyc, 1);
    @(negedge clk);
    #1;
    chk({nm, "_status_pulse_count"}, st_cnt, 1);
    chk({nm, "_status_err"}, st_err, exp_err);
    chk({nm, "_ready_after_status"}, desc_ready, 1);
    chk({nm, "_beats"}, beats_seen, exp_beats);
    chk({nm, "_ar_count"}, ar_cnt, exp_ars);
    chk({nm, "_tlast_count"}, tlast_cnt, (exp_beats > 0) ? 1 : 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int cyc;
    desc_valid = 0;
    desc_data = '0;
    desc_user = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_desc_ready", desc_ready, 1);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_arlen", m_axi_arlen, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tkeep", m_axis_tkeep, 0);
    chk("rst_status_valid", status_valid, 0);
    @(negedge clk);
    rstn = 1;

    run_desc("t1", 32'h1000, 64, 65'h1_0000_0000_0000_0011,
             -1, 0, 4'd0, 16, 1);
    chk("t1_ar0_addr", ar_a[0], 32'h1000);
    chk("t1_ar0_len", ar_l[0], 8'd15);

    run_desc("t2", 32'h0FF8, 32, 65'h0_DEAD_BEEF_0000_0022,
             -1, 0, 4'd0, 8, 2);
    chk("t2_ar0_addr", ar_a[0], 32'h0FF8);
    chk("t2_ar0_len", ar_l[0], 8'd1);
    chk("t2_ar1_addr", ar_a[1], 32'h1000);
    chk("t2_ar1_len", ar_l[1], 8'd5);

    run_desc("t3_len6", 32'h0100, 6, 65'h3, -1, 0, 4'd1, 0, 0);
    run_desc("t4_len0", 32'h0100, 0, 65'h4, -1, 0, 4'd1, 0, 0);
    run_desc("t5_misalign", 32'h0102, 16, 65'h5, -1, 0, 4'd1, 0, 0);

    run_desc("t6_slverr", 32'h0200, 16, 65'h1_0000_0000_0000_0006,
             2, 0, 4'd2, 4, 1);
    chk("t6_ar0_len", ar_l[0], 8'd3);

    run_desc("t7_rlast", 32'h0300, 16, 65'h7, -1, 1, 4'd4, 4, 1);

    tgl = 1;
    ar_delay = 5;
    run_desc("t8_throttle", 32'h3000, 40, 65'h8, -1, 0, 4'd0, 10, 1);
    chk("t8_ar0_addr", ar_a[0], 32'h3000);
    chk("t8_ar0_len", ar_l[0], 8'd9);
    tgl = 0;
    ar_delay = 0;

    send_desc(32'h2000, 64, 65'h9, -1, 0);
    cyc = 0;
    while (beats_seen < 3 && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("t9_reached_data", 1'(beats_seen >= 3), 1);
    rstn = 0;
    #1;
    chk("t9_abort_arvalid", m_axi_arvalid, 0);
    chk("t9_abort_tvalid", m_axis_tvalid, 0);
    chk("t9_abort_rready", m_axi_rready, 0);
    chk("t9_abort_status", status_valid, 0);
    chk("t9_abort_desc_ready", desc_ready, 1);
    repeat (3) @(negedge clk);
    rstn = 1;
    repeat (20) @(negedge clk);
    #1;
    chk("t9_no_status_pulse", st_cnt, 0);

    run_desc("t10", 32'h0FFC, 8, 65'h1_FFFF_FFFF_FFFF_FFFF,
             -1, 0, 4'd0, 2, 2);
    chk("t10_ar0_len", ar_l[0], 8'd0);
    chk("t10_ar1_addr", ar_a[1], 32'h1000);

    run_desc("t11_wrap", 32'hFFFF_FFF8, 16, 65'hB, -1, 0, 4'd0, 4, 2);
    chk("t11_ar0_len", ar_l[0], 8'd1);
    chk("t11_ar1_addr", ar_a[1], 32'h0);
    chk("t11_ar1_len", ar_l[1], 8'd1);

`ifdef DMA_MM2S_STATS_EN
    chk("stat_desc_count", stat_desc_count, 32'd2);
    chk("stat_beat_count", stat_beat_count, 32'd6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
